// File: rtl/parity_check_serial.sv
// Bit-serial RX parity checker: accumulates parity as data bits arrive, checks the
// received parity bit, and keeps per-frame, sticky and counted error status.
module parity_check_serial #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                 clk_RX,
  input  logic                 rst,
  input  logic                 frame_start,
  input  logic                 data_bit_vld,
  input  logic                 par_bit_vld,
  input  logic                 sampled_bit,
  input  logic                 PAR_EN,
  input  logic [1:0]           PAR_TYP,
  input  logic                 err_clr,
  output logic                 Parity_Error,
  output logic                 check_done,
  output logic                 par_err_sticky,
  output logic [CNT_WIDTH-1:0] err_count
);

  localparam int BC_W = $clog2(DATA_WIDTH + 1);
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;

  state_t          state, state_nxt;
  logic            acc;
  logic [BC_W-1:0] bit_cnt;
  logic            par_en_l;
  logic [1:0]      par_typ_l;
  logic            last_bit;
  logic            frame_fin;
  logic            frame_err;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  function automatic logic expected_parity(input logic a, input logic [1:0] typ);
    case (typ)
      2'b00:   return a;
      2'b01:   return ~a;
      2'b10:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  assign last_bit = data_bit_vld && (bit_cnt == LAST_BIT);

  always_ff @(posedge clk_RX or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // frame_start overrides everything, including a coincident data or parity bit
  always_comb begin
    state_nxt = state;
    if (frame_start) begin
      state_nxt = DATA;
    end else begin
      case (state)
        DATA:    if (last_bit) state_nxt = par_en_l ? PARITY : IDLE;
        PARITY:  if (par_bit_vld) state_nxt = IDLE;
        default: state_nxt = state;
      endcase
    end
  end

  always_comb begin
    frame_fin = 1'b0;
    frame_err = 1'b0;
    if (!frame_start) begin
      case (state)
        DATA:    frame_fin = last_bit && !par_en_l;
        PARITY:  begin
          frame_fin = par_bit_vld;
          frame_err = par_bit_vld && (sampled_bit != expected_parity(acc, par_typ_l));
        end
        default: ;
      endcase
    end
  end

  // stage p0 -> registered status; everything lands one cycle after the completing bit
  always_ff @(posedge clk_RX or negedge rst) begin
    if (!rst) begin
      acc            <= 1'b0;
      bit_cnt        <= '0;
      par_en_l       <= 1'b0;
      par_typ_l      <= 2'b00;
      check_done     <= 1'b0;
      Parity_Error   <= 1'b0;
      par_err_sticky <= 1'b0;
      err_count      <= '0;
    end else begin
      check_done <= frame_fin;
      if (frame_start) begin
        acc       <= 1'b0;
        bit_cnt   <= '0;
        par_en_l  <= PAR_EN;
        par_typ_l <= PAR_TYP;
      end else if (state == DATA && data_bit_vld) begin
        acc     <= acc ^ sampled_bit;
        bit_cnt <= bit_cnt + BC_W'(1);
      end
      if (frame_fin) Parity_Error <= frame_err;
      // a clear coincident with a new error leaves that error recorded
      if (err_clr) begin
        par_err_sticky <= frame_err;
        err_count      <= frame_err ? CNT_WIDTH'(1) : '0;
      end else if (frame_err) begin
        par_err_sticky <= 1'b1;
        err_count      <= sat_inc(err_count);
      end
    end
  end

endmodule

// File: tb/tb_parity_check_serial.sv
// Directed bench for parity_check_serial (DATA_WIDTH=8, CNT_WIDTH=2 to reach saturation).
module tb_parity_check_serial;

  logic       clk_RX;
  logic       rst;
  logic       frame_start;
  logic       data_bit_vld;
  logic       par_bit_vld;
  logic       sampled_bit;
  logic       PAR_EN;
  logic [1:0] PAR_TYP;
  logic       err_clr;
  logic       Parity_Error;
  logic       check_done;
  logic       par_err_sticky;
  logic [1:0] err_count;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;

  parity_check_serial #(.DATA_WIDTH(8), .CNT_WIDTH(2)) dut (
    .clk_RX        (clk_RX),
    .rst           (rst),
    .frame_start   (frame_start),
    .data_bit_vld  (data_bit_vld),
    .par_bit_vld   (par_bit_vld),
    .sampled_bit   (sampled_bit),
    .PAR_EN        (PAR_EN),
    .PAR_TYP       (PAR_TYP),
    .err_clr       (err_clr),
    .Parity_Error  (Parity_Error),
    .check_done    (check_done),
    .par_err_sticky(par_err_sticky),
    .err_count     (err_count)
  );

  initial clk_RX = 1'b0;
  always #5 clk_RX = ~clk_RX;

  always @(negedge clk_RX) if (check_done) done_cnt++;

  task automatic tick();
    @(posedge clk_RX);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Config is flipped right after frame_start to confirm the latched copy is used.
  task automatic send_frame(input string tag, input logic [7:0] d, input logic en,
                            input logic [1:0] typ, input logic pbit, input logic clr,
                            input logic inject, input logic exp_pe, input int n_before);
    PAR_EN      = en;
    PAR_TYP     = typ;
    frame_start = 1'b1;
    if (inject) begin
      data_bit_vld = 1'b1;
      sampled_bit  = 1'b1;
    end
    tick();
    frame_start  = 1'b0;
    data_bit_vld = 1'b0;
    PAR_EN       = ~en;
    PAR_TYP      = ~typ;
    for (int i = 0; i < 8; i++) begin
      data_bit_vld = 1'b1;
      sampled_bit  = d[i];
      tick();
      data_bit_vld = 1'b0;
      if (inject && i == 2) begin
        par_bit_vld = 1'b1;
        sampled_bit = 1'b1;
        tick();
        par_bit_vld = 1'b0;
      end
      if (i == 6) chk($sformatf("%s_early_done", tag), check_done, 0);
    end
    if (en) begin
      chk($sformatf("%s_done_before_par", tag), check_done, 0);
      par_bit_vld = 1'b1;
      sampled_bit = pbit;
      err_clr     = clr;
      tick();
      par_bit_vld = 1'b0;
      err_clr     = 1'b0;
    end
    chk($sformatf("%s_done", tag), check_done, 1);
    chk($sformatf("%s_perr", tag), Parity_Error, exp_pe);
    tick();
    chk($sformatf("%s_done_fall", tag), check_done, 0);
    chk($sformatf("%s_done_pulses", tag), done_cnt - n_before, 1);
  endtask

  initial begin
    rst          = 1'b0;
    frame_start  = 1'b0;
    data_bit_vld = 1'b0;
    par_bit_vld  = 1'b0;
    sampled_bit  = 1'b0;
    PAR_EN       = 1'b0;
    PAR_TYP      = 2'b00;
    err_clr      = 1'b0;
    repeat (2) @(posedge clk_RX);
    #1;
    chk("rst_perr", Parity_Error, 0);
    chk("rst_done", check_done, 0);
    chk("rst_sticky", par_err_sticky, 0);
    chk("rst_count", err_count, 0);
    rst = 1'b1;
    tick();

    // 0xA5 has four ones: even expects 0, odd expects 1
    send_frame("even_ok", 8'hA5, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, done_cnt);
    chk("even_ok_count", err_count, 0);
    chk("even_ok_sticky", par_err_sticky, 0);
    send_frame("odd_bad", 8'hA5, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, done_cnt);
    chk("odd_bad_sticky", par_err_sticky, 1);
    chk("odd_bad_count", err_count, 1);
    send_frame("odd_ok", 8'hA5, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, done_cnt);
    chk("odd_ok_sticky", par_err_sticky, 1);
    chk("odd_ok_count", err_count, 1);
    send_frame("space_ok", 8'hA5, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, done_cnt);
    chk("space_ok_count", err_count, 1);
    send_frame("nopar", 8'hA5, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, done_cnt);
    chk("nopar_count", err_count, 1);
    send_frame("mark_bad", 8'hA5, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, done_cnt);
    chk("mark_bad_count", err_count, 2);
    chk("mark_bad_sticky", par_err_sticky, 1);

    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr_count", err_count, 0);
    chk("clr_sticky", par_err_sticky, 0);
    chk("clr_perr_kept", Parity_Error, 1);

    send_frame("sat1", 8'h3C, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, done_cnt);
    chk("sat1_count", err_count, 1);
    send_frame("sat2", 8'h3C, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, done_cnt);
    chk("sat2_count", err_count, 2);
    send_frame("sat3", 8'h3C, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, done_cnt);
    chk("sat3_count", err_count, 3);
    send_frame("sat4", 8'h3C, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, done_cnt);
    chk("sat4_count", err_count, 3);
    send_frame("sat5", 8'h3C, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, done_cnt);
    chk("sat5_count", err_count, 3);
    send_frame("sat_clr", 8'h3C, 1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 1'b1, done_cnt);
    chk("sat_clr_count", err_count, 1);
    chk("sat_clr_sticky", par_err_sticky, 1);

    // Abort after 4 bits, restart with a coincident data bit and a stray parity strobe
    begin
      int n0;
      n0 = done_cnt;
      PAR_EN      = 1'b1;
      PAR_TYP     = 2'b00;
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      for (int i = 0; i < 4; i++) begin
        data_bit_vld = 1'b1;
        sampled_bit  = 1'b1;
        tick();
      end
      data_bit_vld = 1'b0;
      chk("abort_no_done", check_done, 0);
      send_frame("restart", 8'h0F, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, n0);
      chk("restart_count", err_count, 1);
    end

    // Async reset while waiting for the parity bit
    begin
      int n1;
      PAR_EN      = 1'b1;
      PAR_TYP     = 2'b10;
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      for (int i = 0; i < 8; i++) begin
        data_bit_vld = 1'b1;
        sampled_bit  = 1'b0;
        tick();
      end
      data_bit_vld = 1'b0;
      chk("pre_rst_sticky", par_err_sticky, 1);
      #2;
      rst = 1'b0;
      #1;
      chk("arst_perr", Parity_Error, 0);
      chk("arst_done", check_done, 0);
      chk("arst_sticky", par_err_sticky, 0);
      chk("arst_count", err_count, 0);
      n1 = done_cnt;
      tick();
      rst         = 1'b1;
      par_bit_vld = 1'b1;
      sampled_bit = 1'b0;
      tick();
      tick();
      par_bit_vld = 1'b0;
      tick();
      chk("post_rst_no_done", done_cnt - n1, 0);
      send_frame("post_rst", 8'hA5, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, done_cnt);
      chk("post_rst_count", err_count, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/parity_check_serial.md
Name: parity_check_serial

Overview:
Parametrised, bit-serial successor to the UART RX parity checker. It accumulates parity on the fly as the sampler delivers data bits, then compares the result against the received parity bit. It supports even, odd, mark and space parity. It also provides a per-frame error/done strobe, a sticky error flag and a saturating error counter for the RX status register. It sits between the RX data sampler/FSM and the RX status/output logic in the clk_RX domain.

Parameters:
DATA_WIDTH, 8, number of data bits per frame (5..9 supported).
CNT_WIDTH, 8, width of the saturating parity-error counter.

Ports:
clk_RX  input  1  RX oversampling-domain clock.
rst  input  1  reset, asynchronous, active-low.
frame_start  input  1  one-cycle pulse at start-bit acceptance; clears accumulator and latches config.
data_bit_vld  input  1  sampled_bit is a data bit (LSB first).
par_bit_vld  input  1  sampled_bit is the parity bit.
sampled_bit  input  1  majority-voted bit from the sampler.
PAR_EN  input  1  parity enable; latched at frame_start.
PAR_TYP  input  2  00 even, 01 odd, 10 mark (expect 1), 11 space (expect 0); latched at frame_start.
err_clr  input  1  synchronous clear of the sticky flag and counter.
Parity_Error  output  1  result of the last completed frame; held until the next completion.
check_done  output  1  one-cycle pulse when a frame's parity result is final.
par_err_sticky  output  1  set on any parity error; cleared only by err_clr or reset.
err_count  output  CNT_WIDTH  number of parity errors, saturating at all-ones.

Behaviour:
- Reset (rst low, async): state=IDLE, accumulator=0, bit counter=0; Parity_Error=0, check_done=0, par_err_sticky=0, err_count=0; latched config is PAR_EN=0, PAR_TYP=00.
- FSM states: IDLE, DATA, PARITY.
- IDLE: only frame_start has an effect. On frame_start: accumulator<=0, bit counter<=0, latch PAR_EN/PAR_TYP, go to DATA. data_bit_vld and par_bit_vld are ignored.
- DATA: each data_bit_vld does accumulator <= accumulator ^ sampled_bit and increments the bit counter.
  - On the DATA_WIDTH-th bit with latched PAR_EN=1: go to PARITY.
  - On the DATA_WIDTH-th bit with latched PAR_EN=0: go to IDLE, pulse check_done in the following cycle with Parity_Error<=0; counter and sticky flag unchanged.
  - par_bit_vld is ignored in DATA.
- PARITY: on par_bit_vld, compute expected = acc (even), ~acc (odd), 1 (mark), 0 (space). Then Parity_Error <= (sampled_bit != expected). check_done is asserted in the cycle after par_bit_vld (1-cycle latency), and the FSM returns to IDLE.
- Error side effects at completion: if Parity_Error is set, par_err_sticky<=1 and err_count increments, saturating at 2^CNT_WIDTH-1 (no wrap).
- frame_start in DATA or PARITY aborts the current frame with no check_done and no error update, then restarts as from IDLE.
- frame_start coincident with data_bit_vld/par_bit_vld: frame_start wins, and the bit is not accumulated.
- err_clr coincident with a completing error: error is counted after the clear, so err_count=1 and par_err_sticky=1. err_clr alone: err_count=0, par_err_sticky=0; Parity_Error is not affected.
- Config changes outside frame_start have no effect on the frame in progress.
- Async reset mid-frame returns everything to reset values immediately; no check_done is produced for the aborted frame.
- All outputs are registered. No combinational input-to-output path.

Test Plan:
- Even parity, DATA_WIDTH=8, data 0xA5 (LSB first), parity bit 0 -> check_done pulse 1 cycle after par_bit_vld, Parity_Error=0, err_count=0.
- Odd parity, data 0xA5, parity bit 0 -> Parity_Error=1, par_err_sticky=1, err_count=1. Next frame with correct bit 1 -> Parity_Error=0, sticky stays 1, count stays 1.
- Mark/space: PAR_TYP=10 with parity bit 0 -> error. PAR_TYP=11 with parity bit 0 -> no error. PAR_EN=0 frame -> check_done after 8th data bit, Parity_Error=0, counter unchanged.
- CNT_WIDTH=2: inject 5 erroneous frames -> err_count sequence 1,2,3,3,3. err_clr in the same cycle as the 6th error -> err_count=1.
- frame_start after 4 data bits, then a full 8-bit frame 0x0F with even parity 0 -> exactly one check_done, Parity_Error=0. par_bit_vld during DATA is ignored.
- Assert rst low while in PARITY -> all outputs 0 immediately; no check_done after release; next frame completes normally.
